// File: rtl/fifo_unpack_pkg.sv
// Shared types and elaboration helpers for the FIFO read-side unpacker.
package fifo_unpack_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Legal when the input word splits into an integer number (>= 2) of beats.
  function automatic bit ratio_ok(input int in_w, input int out_w);
    if (out_w <= 0) return 1'b0;
    if ((in_w % out_w) != 0) return 1'b0;
    return (in_w / out_w) >= 2;
  endfunction

  // Width of the beat index counter, never narrower than one bit.
  function automatic int cnt_width(input int ratio);
    if (ratio <= 2) return 1;
    return $clog2(ratio);
  endfunction

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int DEF_RATIO     = DEF_IN_WIDTH / DEF_OUT_WIDTH;
  localparam int CNT_W         = cnt_width(DEF_RATIO);

endpackage

// File: rtl/fifo_unpack_shreg.sv
// Loadable shift register presenting one narrow beat of a wide word.
// Beat order is LSB first by default; defining FIFO_UNPACK_MSB_FIRST_EN
// makes it MSB first (left shift, beat taken from the top bits).
module fifo_unpack_shreg #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] beat_o
);

  logic [IN_WIDTH-1:0] shreg_q;
  logic [IN_WIDTH-1:0] shreg_d;

  // Next word contents: load wins over shift, otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      shreg_d = shreg_q << OUT_WIDTH;
`else
      shreg_d = shreg_q >> OUT_WIDTH;
`endif
    end
  end

  // Holding register; cleared on reset so the output beat reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign beat_o = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
`else
  assign beat_o = shreg_q[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Read-side unpacker for a first-word-fall-through FIFO: pops one wide word
// and emits it as IN_WIDTH/OUT_WIDTH beats on a valid/ready stream.
// Optional build macro FIFO_UNPACK_MSB_FIRST_EN selects MSB-first beat order.
module fifo_rd_unpacker
  import fifo_unpack_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                                       rd_clk,
  input  logic                                       rd_rst,
  input  logic [IN_WIDTH-1:0]                        fifo_dout,
  input  logic                                       fifo_empty,
  output logic                                       fifo_rd_en,
  output logic [OUT_WIDTH-1:0]                       m_data,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic                                       m_last,
  output logic [cnt_width(IN_WIDTH/OUT_WIDTH)-1:0]   beat_idx
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = cnt_width(RATIO);

  if (!ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
    $error("fifo_rd_unpacker: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          load, shift;
  logic          xfer, at_last;

  assign m_valid  = (state_q == ST_HOLD);
  assign at_last  = (idx_q == CW'(RATIO - 1));
  assign m_last   = m_valid & at_last;
  assign xfer     = m_valid & m_ready;
  assign beat_idx = idx_q;

  // Pop only when data is present and the holding register is free or
  // being freed by the final beat this cycle (no bubble between words).
  assign fifo_rd_en = ~fifo_empty & ((state_q == ST_EMPTY) | (xfer & m_last));

  // Next-state and datapath controls for the EMPTY/HOLD machine.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (fifo_rd_en) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      load    = 1'b1;
    end else if (xfer && at_last) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
    end else if (xfer) begin
      idx_d   = idx_q + 1'b1;
      shift   = 1'b1;
    end
  end

  // State and beat counter; async reset discards any partially sent word.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  fifo_unpack_shreg #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_shreg (
    .clk_i   (rd_clk),
    .rst_i   (rd_rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (fifo_dout),
    .beat_o  (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Scoreboard bench for fifo_rd_unpacker with a behavioural FWFT FIFO model.
module tb_fifo_rd_unpacker;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int R  = IW / OW;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [IW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [1:0]    beat_idx;

  fifo_rd_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .beat_idx   (beat_idx)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fq[$];
  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, xfers = 0, first_x = 0, last_x = 0;
  logic pop_pend = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic [1:0] prev_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: beat k of word w in emission order.
  function automatic logic [7:0] beat_of(input logic [31:0] w, input int k);
    logic [31:0] t;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    t = w >> (8 * (R - 1 - k));
`else
    t = w >> (8 * k);
`endif
    return t[7:0];
  endfunction

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? 32'h0 : fq[0];
  endfunction

  task automatic push_word(input logic [31:0] w);
    beat_t b;
    fq.push_back(w);
    for (int k = 0; k < R; k++) begin
      b.d = beat_of(w, k);
      b.idx = 2'(k);
      b.last = (k == R - 1);
      exp_q.push_back(b);
    end
    refresh();
  endtask

  // One rd_clk cycle; the FIFO model applies a pop seen in the previous cycle.
  task automatic tick();
    @(posedge rd_clk);
    #1;
    if (pop_pend) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pop_pend = 1'b0;
    end
    refresh();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: compares every accepted beat against the scoreboard.
  always @(negedge rd_clk) begin
    beat_t e;
    cyc++;
    if (!rd_rst) begin
      if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 1, 0);
      if (fifo_rd_en) begin
        pops++;
        pop_pend = 1'b1;
      end
      if (prev_stall) begin
        chk("stall_data", m_data, prev_d);
        chk("stall_idx", beat_idx, prev_idx);
        chk("stall_valid", m_valid, 1);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h idx %0d, none expected", m_data, beat_idx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.d);
          chk("beat_idx", beat_idx, e.idx);
          chk("beat_last", m_last, e.last);
        end
        if (xfers == 0) first_x = cyc;
        xfers++;
        last_x = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_idx   = beat_idx;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n;
    int pushed;
    logic [31:0] w;

    rd_rst = 1'b1;
    m_ready = 1'b0;
    refresh();
    repeat (3) @(posedge rd_clk);
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat_idx", beat_idx, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    tick();
    rd_rst = 1'b0;
    tick();

    // Single word, m_ready high: latency and beat order.
    m_ready = 1'b1;
    pops = 0; xfers = 0;
    push_word(32'hA1B2C3D4);
    #3;
    chk("t1_rd_en_cycle_n", fifo_rd_en, 1);
    chk("t1_valid_cycle_n", m_valid, 0);
    tick(); #3;
    chk("t1_valid_n1", m_valid, 1);
    chk("t1_first_beat", m_data, beat_of(32'hA1B2C3D4, 0));
    drain("t1", 20);
    tick(); #3;
    chk("t1_valid_after", m_valid, 0);
    chk("t1_pops", pops, 1);
    chk("t1_contig", last_x - first_x, R - 1);

    // Back-to-back words: no bubble.
    pops = 0; xfers = 0;
    push_word(32'h03020100);
    push_word(32'h07060504);
    drain("t2", 40);
    tick();
    chk("t2_pops", pops, 2);
    chk("t2_xfers", xfers, 8);
    chk("t2_contig", last_x - first_x, 7);

    // Backpressure at beat 2.
    push_word(32'h44332211);
    n = 0;
    do begin
      tick(); #3; n++;
    end while (!(m_valid && beat_idx == 2) && n < 20);
    chk("t3_reach_beat2", n < 20, 1);
    m_ready = 1'b0;
    push_word(32'h88776655);
    pops = 0;
    repeat (5) begin
      tick(); #3;
      chk("t3_hold_data", m_data, beat_of(32'h44332211, 2));
      chk("t3_hold_idx", beat_idx, 2);
      chk("t3_no_rd_en", fifo_rd_en, 0);
    end
    chk("t3_pops_during_stall", pops, 0);
    m_ready = 1'b1;
    drain("t3", 40);

    // Reset mid-word after beat 1 has been taken.
    tick();
    push_word(32'hDEADBEEF);
    n = 0;
    do begin
      tick(); #3; n++;
    end while (!(m_valid && beat_idx == 2) && n < 20);
    chk("t4_reach_beat2", n < 20, 1);
    rd_rst = 1'b1;
    fq.delete();
    exp_q.delete();
    pop_pend = 1'b0;
    refresh();
    #1;
    chk("t4_async_valid", m_valid, 0);
    chk("t4_async_idx", beat_idx, 0);
    tick();
    rd_rst = 1'b0;
    tick();
    push_word(32'h5A5A0F0F);
    drain("t4", 20);

    // Random words with 50% m_ready.
    pushed = 0; n = 0;
    while ((pushed < 64 || exp_q.size() > 0) && n < 5000) begin
      tick();
      m_ready = $urandom_range(0, 1) != 0;
      if (pushed < 64 && $urandom_range(0, 2) == 0) begin
        w = $urandom;
        push_word(w);
        pushed++;
      end
      n++;
    end
    chk("t5_all_pushed", pushed, 64);
    chk("t5_drained", exp_q.size(), 0);
    m_ready = 1'b1;
    repeat (4) tick();
    chk("t5_idle_valid", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
- Read-side consumer of the team's first-word-fall-through async FIFO, in the rd_clk domain.
- Pops one IN_WIDTH word, then emits it as RATIO = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream.
- Sits between the FIFO read port and narrow downstream logic (UART/SPI byte engines, narrow AXI-Stream sinks).

Parameters:
IN_WIDTH, 32, FIFO word width; must equal the FIFO's DATA_WIDTH.
OUT_WIDTH, 8, output beat width; IN_WIDTH must be an integer multiple, with RATIO >= 2 (elaboration error otherwise).

Ports:
rd_clk  in  1  read-domain clock.
rd_rst  in  1  reset, asynchronous, active-high; clock rd_clk. Same reset as the FIFO read side.
fifo_dout  in  IN_WIDTH  FIFO data; FWFT, valid whenever fifo_empty=0.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  pop strobe to the FIFO; combinational.
m_data  out  OUT_WIDTH  output beat; registered.
m_valid  out  1  output beat valid; registered.
m_ready  in  1  downstream accept.
m_last  out  1  high on the final beat of a word.
beat_idx  out  clog2(RATIO)  index of the current beat, 0..RATIO-1.

Behaviour:
- State machine has two states:
  - EMPTY: holding register invalid.
  - HOLD: word loaded, beats being presented.
- Beat transfer = m_valid & m_ready.
- Word load:
  - fifo_rd_en = ~fifo_empty & (state==EMPTY | (transfer & m_last)).
  - On fifo_rd_en, the shift register captures fifo_dout, beat_idx<=0, state<=HOLD, m_valid<=1.
- Latency:
  - fifo_empty falls at edge n while in EMPTY: fifo_rd_en is high in cycle n and m_valid is high from edge n+1.
  - Back-to-back words (FIFO non-empty when the last beat is taken) produce no bubble: beat 0 of the next word appears on the cycle after the last beat of the previous word.
- Beat order: LSB first. Beat k = bits [k*OUT_WIDTH +: OUT_WIDTH]. On each non-last transfer, shift right by OUT_WIDTH and increment beat_idx.
- m_last = m_valid & (beat_idx==RATIO-1).
- Last beat taken with the FIFO empty: state<=EMPTY, m_valid<=0 next cycle, fifo_rd_en stays low.
- Backpressure: while m_valid & ~m_ready, m_data, beat_idx, m_last and the holding register stay stable. No pop occurs.
- m_valid never drops without a transfer (AXI-Stream rule).
- Never pops while fifo_empty=1 (guarded in the rd_en equation, not relying on the FIFO's internal guard).
- Reset values: m_valid=0, m_data=0, beat_idx=0, state=EMPTY, fifo_rd_en=0 (fifo_empty is 1 under reset).
- Reset mid-word: the partially sent word is discarded and no further beats of it appear. The FIFO read pointer is reset by the same rd_rst.
- Simultaneous last-beat transfer and FIFO non-empty: pop and load in the same cycle. The transfer takes priority over the idle check.

Optional Feature:
FIFO_UNPACK_MSB_FIRST_EN
- Defined: beats are emitted MSB first. Beat k = bits [IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH], and the shift is left.
- Undefined: LSB first, as above.
- Timing, handshakes and beat_idx are identical in both builds.

Decomposition:
- Package fifo_unpack_pkg holds:
  - state enum (ST_EMPTY, ST_HOLD);
  - localparam function for the RATIO check;
  - CNT_W = clog2(RATIO).
- One sub-module, fifo_unpack_shreg: loadable shift register with load/shift/direction controls; the direction is fixed by the macro.
- The FSM and handshake logic stay in the top module.

Test Plan:
- Single word, m_ready=1: FIFO holds 32'hA1B2C3D4 -> one fifo_rd_en pulse, then beats B2? no -> beats D4,C3,B2,A1 on 4 consecutive cycles, m_last only on A1, then m_valid=0.
- Back-to-back words: FIFO holds 32'h03020100 and 32'h07060504, m_ready=1 -> 8 contiguous beats 00..07, exactly 2 rd_en pulses, no gap cycle.
- Backpressure: m_ready=0 for 5 cycles at beat 2 of 32'h44332211 -> m_data holds 8'h33, beat_idx=2, no rd_en; resumes with 33,44.
- Random m_ready (50%) with 64 random words through the real async FIFO (wr_clk 100 MHz, rd_clk 37 MHz) -> output byte stream equals the scoreboard; rd_en never asserted while fifo_empty=1.
- rd_rst pulsed after beat 1 of 32'hDEADBEEF -> m_valid=0 asynchronously; no 8'hAD/8'hDE beats follow; the next written word starts at beat_idx=0.
- MSB-first build: 32'hA1B2C3D4 -> beats A1,B2,C3,D4.
